// File: rtl/vecmac_pkg.sv
// Shared definitions for the vector MAC datapath (streamer, adder tree, accumulator).
//   LANES  : int8 elements carried per beat
//   ELEM_W : element width in bits
//   BEATS  : beats per vector (1000 elements / LANES)
//   BEAT_W : packed width of one beat word, lane 0 in the low bits
//   state_e: sequencing states shared by the streaming blocks
package vecmac_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned BEATS  = 250;
    localparam int unsigned BEAT_W = LANES * ELEM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/vec_beat_streamer_if.sv
// Valid/ready beat stream carrying one A word, one B word and a last flag per beat.
//   out_valid : beat available (master)
//   out_ready : downstream accepts beat (slave)
//   out_a     : A lanes, lane 0 in bits [ELEM_W-1:0] (master)
//   out_b     : B lanes, same packing (master)
//   out_last  : marks the final beat of a vector (master)
interface vec_beat_streamer_if import vecmac_pkg::*; ();

    logic              out_valid;
    logic              out_ready;
    logic [BEAT_W-1:0] out_a;
    logic [BEAT_W-1:0] out_b;
    logic              out_last;

    modport master (
        output out_valid,
        output out_a,
        output out_b,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_a,
        input  out_b,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/vec_beat_streamer_beat_fifo.sv
// Two-entry first-word-fall-through FIFO; the head entry is visible on dout while non-empty.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data; a push on a full FIFO is accepted only with a pop
//   pop      : removes the head entry when non-empty
//   dout     : head entry
//   full, empty, count : occupancy status
module beat_fifo #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // On full, the pushed word lands in the slot being vacated by the pop.
    assign do_push = push && (!full || pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vec_beat_streamer.sv
// Streams two int8 vectors (A, B) from synchronous-read buffers as BEATS beats of LANES
// elements over a valid/ready stream, sustaining one beat per cycle under backpressure.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : command pulse, accepted only when idle
//   base_addr      : first beat address, sampled on accepted start
//   busy, done     : command in progress / one-cycle completion pulse
//   mem_rd_en      : read strobe shared by the A and B buffers
//   mem_addr       : read address (base_addr + beat index, wrapping)
//   mem_a_data/_b  : buffer words, valid one cycle after mem_rd_en
//   stream         : output beat stream (master side)
module vec_beat_streamer import vecmac_pkg::*; #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MEM_AW-1:0]   base_addr,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [BEAT_W-1:0]   mem_a_data,
    input  logic [BEAT_W-1:0]   mem_b_data,
    vec_beat_streamer_if.master stream
);

    localparam int unsigned IW     = $clog2(BEATS);
    localparam int unsigned FIFO_W = 2 * BEAT_W + 1;

    state_e              state_q, state_d;
    logic                busy_q;
    logic                done_q;
    logic                inflight_q;
    logic                inflight_last_q;
    logic [MEM_AW-1:0]   base_q;
    logic [IW-1:0]       issue_q;

    logic                start_ok;
    logic                pop;
    logic                last_pop;
    logic                last_issue;
    logic [2:0]          occ;
    logic [FIFO_W-1:0]   fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [1:0]          fifo_count;

    assign start_ok   = start && (state_q == IDLE) && !busy_q;
    assign pop        = stream.out_valid && stream.out_ready;
    assign last_pop   = pop && stream.out_last;
    // Words held or on their way back, after this cycle's pop; keeps the FIFO from overfilling
    // while still issuing every cycle when the consumer is always ready.
    assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign mem_rd_en  = (state_q == RUN) && (occ < 3'd2);
    assign last_issue = mem_rd_en && (issue_q == IW'(BEATS - 1));
    assign mem_addr   = base_q + MEM_AW'(issue_q);

    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok)   state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (last_pop)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            base_q          <= '0;
            issue_q         <= '0;
        end else begin
            state_q         <= state_d;
            done_q          <= (state_q == DRAIN) && last_pop;
            inflight_q      <= mem_rd_en;
            inflight_last_q <= last_issue;
            if (start_ok) begin
                busy_q  <= 1'b1;
                base_q  <= base_addr;
                issue_q <= '0;
            end else begin
                if (done_q) begin
                    busy_q <= 1'b0;
                end
                if (mem_rd_en) begin
                    issue_q <= issue_q + 1'b1;
                end
            end
        end
    end

    beat_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   ({inflight_last_q, mem_b_data, mem_a_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign stream.out_valid = !fifo_empty;
    assign {stream.out_last, stream.out_b, stream.out_a} = fifo_dout;

    // The issue rule guarantees a returning word always finds room.
    assert property (@(posedge clk) disable iff (rst) !(inflight_q && fifo_full && !pop));

endmodule

// File: tb/tb_vec_beat_streamer.sv
module tb_vec_beat_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_a_data;
    logic [31:0] mem_b_data;

    vec_beat_streamer_if bus ();

    vec_beat_streamer #(
        .MEM_AW (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_a_data (mem_a_data),
        .mem_b_data (mem_b_data),
        .stream     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffers
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_a_data <= mem_a[mem_addr];
            mem_b_data <= mem_b[mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state, sampled on the falling edge
    int          cyc = 0, n_hs = 0, n_rd = 0, n_done = 0, n_busy = 0;
    int          stab_err = 0, overfill = 0, outstanding = 0;
    int          start_cyc = 0, rd_lat = -1, v_lat = -1;
    bit          want_rd = 0, want_v = 0, hold_pending = 0;
    logic [64:0] held;
    logic [31:0] hs_a [4096];
    logic [31:0] hs_b [4096];
    bit          hs_last [4096];
    logic [9:0]  addr_log [4096];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hold_pending = 0;
            outstanding  = 0;
        end else begin
            if (hold_pending && (!bus.out_valid ||
                {bus.out_last, bus.out_b, bus.out_a} !== held)) stab_err++;
            if (outstanding > 2) overfill++;
            hold_pending = bus.out_valid && !bus.out_ready;
            held = {bus.out_last, bus.out_b, bus.out_a};
            if (start && !busy) begin
                start_cyc = cyc; want_rd = 1; want_v = 1;
            end
            if (want_rd && mem_rd_en) begin rd_lat = cyc - start_cyc; want_rd = 0; end
            if (want_v && bus.out_valid) begin v_lat = cyc - start_cyc; want_v = 0; end
            if (bus.out_valid && bus.out_ready) begin
                hs_a[n_hs] = bus.out_a; hs_b[n_hs] = bus.out_b; hs_last[n_hs] = bus.out_last;
                n_hs++;
                outstanding--;
            end
            if (mem_rd_en) begin
                addr_log[n_rd] = mem_addr;
                n_rd++;
                outstanding++;
            end
            if (done) n_done++;
            if (busy) n_busy++;
        end
    end

    task automatic fill_ramp();
        for (int w = 0; w < 1024; w++) begin
            for (int j = 0; j < 4; j++) mem_a[w][j*8 +: 8] = 8'((4 * w + j) % 256);
            mem_b[w] = 32'h0101_0101;
        end
    endtask

    // Issues one command and waits (bounded) for done; optionally toggles ready and re-pulses start.
    task automatic run_cmd(input logic [9:0] b, input bit toggle, input bit repulse,
                           output bit timed_out);
        int h0, d0;
        bit p10, p249;
        h0 = n_hs; d0 = n_done; p10 = 0; p249 = 0; timed_out = 1;
        @(posedge clk); #1;
        base_addr = b; start = 1; bus.out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 3000; c++) begin
            if (toggle) bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
            start = 0;
            if (repulse && !p10 && n_hs - h0 >= 10) begin start = 1; p10 = 1; end
            else if (repulse && !p249 && n_hs - h0 >= 249) begin start = 1; p249 = 1; end
            @(posedge clk); #1;
            if (n_done != d0) begin timed_out = 0; break; end
        end
        start = 0;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Counts beats in [h0, h0+250) whose data differs from the ramp image at base b.
    function automatic int ramp_errors(input int h0, input logic [9:0] b);
        int bad = 0;
        logic [31:0] exp_a;
        for (int k = 0; k < 250; k++) begin
            int w = (int'(b) + k) % 1024;
            for (int j = 0; j < 4; j++) exp_a[j*8 +: 8] = 8'((4 * w + j) % 256);
            if (hs_a[h0+k] !== exp_a || hs_b[h0+k] !== 32'h0101_0101) bad++;
        end
        return bad;
    endfunction

    function automatic int last_count(input int h0);
        int n = 0;
        for (int k = 0; k < 250; k++) if (hs_last[h0+k]) n++;
        return n;
    endfunction

    task automatic test_reset();
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
        n_tests++; if (mem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", bus.out_last); end
        n_tests++; if ({bus.out_a, bus.out_b} !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {bus.out_a, bus.out_b}); end
    endtask

    task automatic test_stream();
        int h0, d0, b0; bit to;
        h0 = n_hs; d0 = n_done; b0 = n_busy;
        run_cmd(10'd0, 0, 0, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL stream_timeout got timeout want done"); end
        n_tests++; if (n_hs - h0 !== 250) begin n_fail++; $display("FAIL stream_beats got %0d want 250", n_hs - h0); end
        n_tests++; if (ramp_errors(h0, 10'd0) !== 0) begin n_fail++; $display("FAIL stream_data got %0d bad beats want 0", ramp_errors(h0, 10'd0)); end
        n_tests++; if (last_count(h0) !== 1 || !hs_last[h0+249]) begin n_fail++; $display("FAIL stream_last got count %0d want 1 on beat 249", last_count(h0)); end
        n_tests++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL stream_done got %0d want 1", n_done - d0); end
        n_tests++; if (n_busy - b0 !== 253) begin n_fail++; $display("FAIL stream_busy got %0d cycles want 253", n_busy - b0); end
        n_tests++; if (rd_lat !== 1) begin n_fail++; $display("FAIL stream_rd_latency got %0d want 1", rd_lat); end
        n_tests++; if (v_lat !== 3) begin n_fail++; $display("FAIL stream_valid_latency got %0d want 3", v_lat); end
    endtask

    task automatic test_backpressure();
        int h0, d0, s0, o0; bit to;
        h0 = n_hs; d0 = n_done; s0 = stab_err; o0 = overfill;
        run_cmd(10'd0, 1, 0, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout got timeout want done"); end
        n_tests++; if (n_hs - h0 !== 250) begin n_fail++; $display("FAIL bp_beats got %0d want 250", n_hs - h0); end
        n_tests++; if (ramp_errors(h0, 10'd0) !== 0) begin n_fail++; $display("FAIL bp_data got %0d bad beats want 0", ramp_errors(h0, 10'd0)); end
        n_tests++; if (stab_err - s0 !== 0) begin n_fail++; $display("FAIL bp_stable got %0d violations want 0", stab_err - s0); end
        n_tests++; if (overfill - o0 !== 0) begin n_fail++; $display("FAIL bp_overfill got %0d want 0", overfill - o0); end
        n_tests++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL bp_done got %0d want 1", n_done - d0); end
    endtask

    task automatic test_wrap();
        int h0, r0, bad; bit to;
        h0 = n_hs; r0 = n_rd; bad = 0;
        run_cmd(10'd1000, 0, 0, to);
        for (int k = 0; k < 250; k++) if (addr_log[r0+k] !== 10'((1000 + k) % 1024)) bad++;
        n_tests++; if (to) begin n_fail++; $display("FAIL wrap_timeout got timeout want done"); end
        n_tests++; if (n_rd - r0 !== 250) begin n_fail++; $display("FAIL wrap_reads got %0d want 250", n_rd - r0); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_addr got %0d bad addresses want 0", bad); end
        n_tests++; if (addr_log[r0+249] !== 10'd225) begin n_fail++; $display("FAIL wrap_final_addr got %0d want 225", addr_log[r0+249]); end
        n_tests++; if (ramp_errors(h0, 10'd1000) !== 0) begin n_fail++; $display("FAIL wrap_data got %0d bad beats want 0", ramp_errors(h0, 10'd1000)); end
        n_tests++; if (!hs_last[h0+249] || last_count(h0) !== 1) begin n_fail++; $display("FAIL wrap_last got count %0d want 1 on beat 249", last_count(h0)); end
    endtask

    task automatic test_restart_ignored();
        int h0, d0; bit to;
        h0 = n_hs; d0 = n_done;
        run_cmd(10'd0, 0, 1, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL restart_timeout got timeout want done"); end
        n_tests++; if (n_hs - h0 !== 250) begin n_fail++; $display("FAIL restart_beats got %0d want 250", n_hs - h0); end
        n_tests++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL restart_done got %0d want 1", n_done - d0); end
        n_tests++; if (ramp_errors(h0, 10'd0) !== 0) begin n_fail++; $display("FAIL restart_data got %0d bad beats want 0", ramp_errors(h0, 10'd0)); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int h0, d0; bit to;
        h0 = n_hs; d0 = n_done;
        @(posedge clk); #1;
        base_addr = 10'd0; start = 1; bus.out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 1000 && n_hs - h0 < 100; c++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1;
        #1;
        n_tests++; if (n_hs - h0 < 100) begin n_fail++; $display("FAIL arst_progress got %0d beats want >= 100", n_hs - h0); end
        n_tests++; if ({busy, mem_rd_en, bus.out_valid, bus.out_last} !== 4'b0) begin n_fail++; $display("FAIL arst_clear got %b want 0000", {busy, mem_rd_en, bus.out_valid, bus.out_last}); end
        n_tests++; if ({bus.out_a, bus.out_b} !== 64'd0) begin n_fail++; $display("FAIL arst_data got %h want 0", {bus.out_a, bus.out_b}); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL arst_no_done got %0d want 0", n_done - d0); end
        h0 = n_hs;
        run_cmd(10'd0, 0, 0, to);
        n_tests++; if (to || n_hs - h0 !== 250) begin n_fail++; $display("FAIL arst_rerun_beats got %0d want 250", n_hs - h0); end
        n_tests++; if (ramp_errors(h0, 10'd0) !== 0) begin n_fail++; $display("FAIL arst_rerun_data got %0d bad beats want 0", ramp_errors(h0, 10'd0)); end
        n_tests++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL arst_rerun_done got %0d want 1", n_done - d0); end
    endtask

    // All-255 vectors: unsigned dot product over the streamed beats must reach 255*255*1000.
    task automatic test_dot_product();
        int h0, sum; bit to;
        for (int w = 0; w < 1024; w++) begin
            mem_a[w] = 32'hFFFF_FFFF;
            mem_b[w] = 32'hFFFF_FFFF;
        end
        h0 = n_hs; sum = 0;
        run_cmd(10'd7, 0, 0, to);
        for (int k = 0; k < 250; k++)
            for (int j = 0; j < 4; j++)
                sum += int'(hs_a[h0+k][j*8 +: 8]) * int'(hs_b[h0+k][j*8 +: 8]);
        n_tests++; if (to || sum !== 65025000) begin n_fail++; $display("FAIL dot_sum got %0d want 65025000", sum); end
        n_tests++; if (!hs_last[h0+249] || last_count(h0) !== 1) begin n_fail++; $display("FAIL dot_last got count %0d want 1 on beat 249", last_count(h0)); end
    endtask

    initial begin
        rst = 1; start = 0; base_addr = '0; bus.out_ready = 0;
        fill_ramp();
        repeat (3) @(posedge clk);
        test_reset();
        #2 rst = 0;
        repeat (2) @(posedge clk);
        test_stream();
        test_backpressure();
        test_wrap();
        test_restart_ignored();
        test_async_reset();
        test_dot_product();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_beat_streamer.md
Name: vec_beat_streamer

Overview:
Transmit side of the beat stream that the MAC datapath consumes. On a start command, reads two int8 vectors (A, B) from synchronous-read buffers and emits them as BEATS beats of LANES elements each over a valid/ready stream. The stream feeds the lane multipliers and adder tree, which drive the accumulator's in_valid/partial_sum. Tolerates downstream backpressure at full throughput through a 2-entry output buffer.

Parameters:
LANES, 4, int8 elements per beat
ELEM_W, 8, element width in bits
BEATS, 250, beats per vector (1000 elems / 4 lanes)
MEM_AW, 10, buffer address width (one address = one beat word)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  command pulse; accepted only in IDLE
base_addr  in  MEM_AW  first beat address, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final beat handshake
mem_rd_en  out  1  read strobe to both A and B buffers
mem_addr  out  MEM_AW  read address, shared by A and B
mem_a_data  in  LANES*ELEM_W  A word, valid 1 cycle after mem_rd_en
mem_b_data  in  LANES*ELEM_W  B word, valid 1 cycle after mem_rd_en
out_valid  out  1  beat available
out_ready  in  1  downstream accepts beat
out_a  out  LANES*ELEM_W  A lanes, lane 0 in bits [ELEM_W-1:0]
out_b  out  LANES*ELEM_W  B lanes, same packing
out_last  out  1  high with beat index BEATS-1

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, mem_rd_en, out_valid, out_last = 0; mem_addr, out_a, out_b = 0; issue and pop counters = 0; FIFO empty; in-flight flag = 0.
- FSM IDLE -> RUN on start; RUN -> DRAIN once BEATS reads are issued; DRAIN -> IDLE on handshake of the beat with out_last. done pulses in the cycle after that handshake. busy is registered and goes high the cycle after start.
- start while busy is ignored with no side effects. start and done in the same cycle are impossible, because done only fires in IDLE-transition cycles.
- Read issue: in RUN, mem_rd_en = 1 iff fifo_count + inflight - pop < 2, where pop = out_valid & out_ready. This is the only combinational path from out_ready. It gives 1 beat/cycle with continuous ready.
- mem_addr = base_addr + issue_idx, modulo 2^MEM_AW, so wrap-around is legal. issue_idx increments per read, 0..BEATS-1.
- Returned data is written into the FIFO the cycle after mem_rd_en, tagged last when its issue index was BEATS-1.
- Output follows stream rules: out_valid = FIFO non-empty. Once out_valid is high, out_a, out_b and out_last hold stable until the handshake. out_valid never drops without a handshake.
- Exactly BEATS handshakes per command. out_last is asserted on exactly one of them.
- FIFO full and read-return in the same cycle cannot occur, because the issue rule forbids it. A simultaneous push and pop on a full FIFO keeps the count unchanged.
- First-beat latency: start at cycle 0 -> mem_rd_en at cycle 1 -> out_valid at cycle 3.
- Reset mid-operation abandons the command. Any in-flight read data is discarded and no done pulse is generated.
- Arithmetic: no data transformation; lanes pass bit-exact.

Decomposition:
- Shared package vecmac_pkg holds LANES, ELEM_W, BEATS, BEAT_W = LANES*ELEM_W, and the FSM state encoding (IDLE, RUN, DRAIN). The package is reused by the accumulator and adder tree.
- One sub-module: beat_fifo, a 2-entry first-word-fall-through FIFO of width 2*BEAT_W+1 with push, pop, full, empty and count outputs.

Test Plan:
- Buffers hold A[i]=i mod 256 and B[i]=1; base_addr=0, ready held 1 -> 250 consecutive beats. Beat k has out_a lanes {4k..4k+3} mod 256. out_last is set only on beat 249. done pulses once; busy is high for exactly 253 cycles.
- Same data with out_ready toggling 1,0,0,1 -> still 250 handshakes in order, with no duplicate or lost beat. Data stays stable while valid && !ready. mem_rd_en never overfills the FIFO (count stays ≤2).
- base_addr=1000 with MEM_AW=10 -> addresses run 1000..1023, then 0..225. The wrap is correct and out_last falls on the address-225 beat.
- start re-pulsed at beats 10 and 249 -> ignored; exactly one done and 250 beats.
- rst=1 asynchronously at beat 100, then released and start issued -> outputs clear immediately with no done. The new run delivers 250 beats starting from base_addr.
- Streamer plus multiplier tree plus accumulator, with A and B all 255 -> final_sum = 65025000 with result_valid, aligned to out_last.
